// File: rtl/branch_hazard_ctrl_if.sv
// rtl/branch_hazard_ctrl_if.sv - ID/EX/MEM hazard inputs and PC-select/stall/flush/counter outputs
// The slave modport belongs to the controller, and the master modport belongs to the pipeline driving it.
interface branch_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             InstrValidD;
  logic             BranchD;
  logic             JumpD;
  logic             JrD;
  logic             CmpResultD;
  logic             UsesRsD;
  logic             UsesRtD;
  logic [4:0]       RsD;
  logic [4:0]       RtD;
  logic             RegWriteE;
  logic             MemReadE;
  logic [4:0]       WriteRegE;
  logic             RegWriteM;
  logic             MemReadM;
  logic [4:0]       WriteRegM;
  logic [1:0]       PCSrc;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] BranchCnt;
  logic [CNT_W-1:0] TakenCnt;
  logic [CNT_W-1:0] StallCnt;

  modport slave (
    input  InstrValidD, BranchD, JumpD, JrD, CmpResultD, UsesRsD, UsesRtD, RsD, RtD,
           RegWriteE, MemReadE, WriteRegE, RegWriteM, MemReadM, WriteRegM,
    output PCSrc, StallF, StallD, FlushD, FlushE, BranchCnt, TakenCnt, StallCnt
  );

  modport master (
    output InstrValidD, BranchD, JumpD, JrD, CmpResultD, UsesRsD, UsesRtD, RsD, RtD,
           RegWriteE, MemReadE, WriteRegE, RegWriteM, MemReadM, WriteRegM,
    input  PCSrc, StallF, StallD, FlushD, FlushE, BranchCnt, TakenCnt, StallCnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch/jump resolution, operand stall sequencing, perf counters
// Branches and jr resolve in ID, so their operands must already be available at that stage.
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  branch_hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JUMP  = 2'b10;
  localparam logic [1:0] PC_JR    = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;

  logic       match_e;
  logic       match_m;
  logic       ctrl_d;
  logic [1:0] nreq;

  logic [1:0] pcsrc;
  logic       stall;
  logic       flush_d;
  logic       resolve;

  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // $0 is hardwired to zero, so a write to it can never feed a consumer.
  always_comb begin
    match_e = bus.RegWriteE && (bus.WriteRegE != 5'd0) &&
              ((bus.UsesRsD && (bus.WriteRegE == bus.RsD)) ||
               (bus.UsesRtD && (bus.WriteRegE == bus.RtD)));
    match_m = bus.RegWriteM && (bus.WriteRegM != 5'd0) &&
              ((bus.UsesRsD && (bus.WriteRegM == bus.RsD)) ||
               (bus.UsesRtD && (bus.WriteRegM == bus.RtD)));
    ctrl_d  = bus.InstrValidD && (bus.BranchD || bus.JrD);
  end

  // A load in EX is two cycles from a value that the ID comparator can use, and an ALU result is one cycle away.
  always_comb begin
    nreq = 2'd0;
    if (ctrl_d && match_e && bus.MemReadE)
      nreq = 2'd2;
    else if (ctrl_d && match_e && !bus.MemReadE)
      nreq = 2'd1;
    else if (ctrl_d && match_m && bus.MemReadM)
      nreq = 2'd1;
    else if (!ctrl_d && bus.InstrValidD && match_e && bus.MemReadE)
      nreq = 2'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pcsrc     = PC_PLUS4;
    stall     = 1'b0;
    flush_d   = 1'b0;
    resolve   = 1'b0;

    case (state)
      IDLE: begin
        if (nreq != 2'd0) begin
          stall = 1'b1;
          if (nreq == 2'd2) begin
            state_nxt = STALL;
            cnt_nxt   = nreq - 2'd1;
          end
        end else begin
          resolve = 1'b1;
          if (bus.InstrValidD) begin
            if (bus.JrD)
              pcsrc = PC_JR;
            else if (bus.JumpD)
              pcsrc = PC_JUMP;
            else if (bus.BranchD && bus.CmpResultD)
              pcsrc = PC_BR;
          end
          flush_d = (pcsrc != PC_PLUS4);
        end
      end

      STALL: begin
        // cnt holds the stall cycles still owed, including this one.
        stall = 1'b1;
        if (cnt <= 2'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase

    if (Rst) begin
      pcsrc   = PC_PLUS4;
      stall   = 1'b0;
      flush_d = 1'b0;
      resolve = 1'b0;
    end
  end

  assign bus.PCSrc  = pcsrc;
  assign bus.StallF = stall;
  assign bus.StallD = stall;
  assign bus.FlushD = flush_d;
  assign bus.FlushE = stall;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (resolve && bus.InstrValidD && (bus.BranchD || bus.JumpD || bus.JrD) &&
          (branch_cnt != CNT_MAX))
        branch_cnt <= branch_cnt + 1'b1;
      if ((pcsrc != PC_PLUS4) && (taken_cnt != CNT_MAX))
        taken_cnt <= taken_cnt + 1'b1;
      if (stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.BranchCnt = branch_cnt;
  assign bus.TakenCnt  = taken_cnt;
  assign bus.StallCnt  = stall_cnt;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - directed scoreboard bench for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

  typedef struct packed {
    logic [1:0] pcsrc;
    logic       sf;
    logic       sd;
    logic       fd;
    logic       fe;
  } exp_t;

  localparam exp_t E0 = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam exp_t ES = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam exp_t EB = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam exp_t EJ = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam exp_t ER = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0};

  logic clk;
  logic rst;
  int   passed;
  int   total;
  exp_t exp_q[$];

  branch_hazard_ctrl_if #(.CNT_W(16)) bus_a();
  branch_hazard_ctrl_if #(.CNT_W(4))  bus_b();

  branch_hazard_ctrl #(.CNT_W(16)) dut_a (.Clk(clk), .Rst(rst), .bus(bus_a));
  branch_hazard_ctrl #(.CNT_W(4))  dut_b (.Clk(clk), .Rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic clr_a();
    bus_a.InstrValidD = 0; bus_a.BranchD = 0; bus_a.JumpD = 0; bus_a.JrD = 0;
    bus_a.CmpResultD = 0; bus_a.UsesRsD = 0; bus_a.UsesRtD = 0;
    bus_a.RsD = 0; bus_a.RtD = 0;
    bus_a.RegWriteE = 0; bus_a.MemReadE = 0; bus_a.WriteRegE = 0;
    bus_a.RegWriteM = 0; bus_a.MemReadM = 0; bus_a.WriteRegM = 0;
  endtask

  task automatic clr_b();
    bus_b.InstrValidD = 0; bus_b.BranchD = 0; bus_b.JumpD = 0; bus_b.JrD = 0;
    bus_b.CmpResultD = 0; bus_b.UsesRsD = 0; bus_b.UsesRtD = 0;
    bus_b.RsD = 0; bus_b.RtD = 0;
    bus_b.RegWriteE = 0; bus_b.MemReadE = 0; bus_b.WriteRegE = 0;
    bus_b.RegWriteM = 0; bus_b.MemReadM = 0; bus_b.WriteRegM = 0;
  endtask

  // Inputs are already driven; record the expectation, sample mid-cycle, then advance past the edge.
  task automatic step(input string tag, input exp_t e);
    exp_t x;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      x = exp_q.pop_front();
      chk({tag, ".PCSrc"},  32'(bus_a.PCSrc),  32'(x.pcsrc));
      chk({tag, ".StallF"}, 32'(bus_a.StallF), 32'(x.sf));
      chk({tag, ".StallD"}, 32'(bus_a.StallD), 32'(x.sd));
      chk({tag, ".FlushD"}, 32'(bus_a.FlushD), 32'(x.fd));
      chk({tag, ".FlushE"}, 32'(bus_a.FlushE), 32'(x.fe));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cnts(input string tag, input int b, input int t, input int s);
    chk({tag, ".BranchCnt"}, 32'(bus_a.BranchCnt), 32'(b));
    chk({tag, ".TakenCnt"},  32'(bus_a.TakenCnt),  32'(t));
    chk({tag, ".StallCnt"},  32'(bus_a.StallCnt),  32'(s));
  endtask

  task automatic load_hazard_beq();
    clr_a();
    bus_a.InstrValidD = 1; bus_a.BranchD = 1; bus_a.UsesRsD = 1; bus_a.RsD = 5;
    bus_a.RegWriteE = 1; bus_a.MemReadE = 1; bus_a.WriteRegE = 5;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1;
    clr_a();
    clr_b();
    @(posedge clk);
    #1;

    // reset forces quiet outputs even with a hazard present
    load_hazard_beq();
    step("rst_forced", E0);
    step("rst_forced2", E0);
    cnts("rst", 0, 0, 0);
    rst = 0;
    clr_a();
    step("idle", E0);

    // taken beq, no hazard
    bus_a.InstrValidD = 1; bus_a.BranchD = 1; bus_a.CmpResultD = 1;
    step("beq_taken", EB);
    cnts("beq_taken", 1, 1, 0);

    // beq after lw in EX: two stall cycles, hazards vanishing mid-stall are ignored
    load_hazard_beq();
    step("lw_beq_s1", ES);
    clr_a();
    bus_a.InstrValidD = 1; bus_a.BranchD = 1; bus_a.UsesRsD = 1; bus_a.RsD = 5;
    step("lw_beq_s2", ES);
    step("lw_beq_res", E0);
    cnts("lw_beq", 2, 1, 2);

    // jr $31 after ALU write in EX: one stall, then an ALU write in MEM needs no stall
    clr_a();
    bus_a.InstrValidD = 1; bus_a.JrD = 1; bus_a.UsesRsD = 1; bus_a.RsD = 31;
    bus_a.RegWriteE = 1; bus_a.WriteRegE = 31;
    step("jr_s1", ES);
    bus_a.RegWriteE = 0; bus_a.WriteRegE = 0;
    bus_a.RegWriteM = 1; bus_a.WriteRegM = 31;
    step("jr_res", ER);
    cnts("jr", 3, 2, 3);

    // load-use on a non-control instruction
    clr_a();
    bus_a.InstrValidD = 1; bus_a.UsesRsD = 1; bus_a.RsD = 8;
    bus_a.RegWriteE = 1; bus_a.MemReadE = 1; bus_a.WriteRegE = 8;
    step("loaduse_s1", ES);
    bus_a.RegWriteE = 0; bus_a.MemReadE = 0; bus_a.WriteRegE = 0;
    step("loaduse_go", E0);
    bus_a.RegWriteE = 1; bus_a.MemReadE = 1; bus_a.WriteRegE = 0;
    step("loaduse_r0", E0);
    bus_a.WriteRegE = 8; bus_a.UsesRsD = 0;
    step("loaduse_unused", E0);
    cnts("loaduse", 3, 2, 4);

    // beq reading Rt with lw in MEM: one stall
    clr_a();
    bus_a.InstrValidD = 1; bus_a.BranchD = 1; bus_a.CmpResultD = 1;
    bus_a.UsesRtD = 1; bus_a.RtD = 9;
    bus_a.RegWriteM = 1; bus_a.MemReadM = 1; bus_a.WriteRegM = 9;
    step("lwm_beq_s1", ES);
    bus_a.RegWriteM = 0; bus_a.MemReadM = 0;
    step("lwm_beq_res", EB);
    cnts("lwm_beq", 4, 3, 5);

    // redirect priority
    clr_a();
    bus_a.InstrValidD = 1; bus_a.JrD = 1; bus_a.JumpD = 1; bus_a.BranchD = 1; bus_a.CmpResultD = 1;
    step("prio_jr", ER);
    bus_a.JrD = 0;
    step("prio_j", EJ);
    bus_a.JumpD = 0; bus_a.CmpResultD = 0;
    step("beq_nt", E0);
    cnts("prio", 7, 5, 5);

    // reset during the first of two stall cycles
    load_hazard_beq();
    rst = 1;
    step("rst_s1", E0);
    rst = 0;
    clr_a();
    step("rst_s1_after", E0);
    cnts("rst_s1", 0, 0, 0);

    // reset while in the STALL state
    load_hazard_beq();
    step("rst_s2_pre", ES);
    rst = 1;
    step("rst_s2", E0);
    rst = 0;
    clr_a();
    step("rst_s2_after", E0);
    cnts("rst_s2", 0, 0, 0);

    // a jump in a bubble slot is ignored
    bus_a.JumpD = 1;
    step("j_invalid", E0);
    cnts("j_invalid", 0, 0, 0);
    clr_a();

    // 4-bit counters saturate
    bus_b.InstrValidD = 1; bus_b.JumpD = 1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
    end
    chk("sat15.TakenCnt", 32'(bus_b.TakenCnt), 32'd15);
    @(posedge clk);
    #1;
    chk("sat16.TakenCnt",  32'(bus_b.TakenCnt),  32'd15);
    chk("sat16.BranchCnt", 32'(bus_b.BranchCnt), 32'd15);
    chk("sat16.StallCnt",  32'(bus_b.StallCnt),  32'd0);
    clr_b();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
